// File: rtl/results_pkg.sv
// Shared constants, state encoding and helpers for the results SRAM write-back path.
package results_pkg;
    localparam int LANES       = 8;
    localparam int IN_W        = 16;
    localparam int ACC_W       = 20;
    localparam int ADDRESSSIZE = 10;
    localparam int WORDSIZE    = LANES * ACC_W;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        MERGE = 2'd2,
        WRITE = 2'd3
    } state_t;

    function automatic logic [ACC_W-1:0] sext_in(input logic [IN_W-1:0] v);
        return {{(ACC_W-IN_W){v[IN_W-1]}}, v};
    endfunction
endpackage

// File: rtl/sat_add_lane.sv
// One lane of the merge adder: stored ACC_W value plus sign-extended partial sum, clamped.
module sat_add_lane
    import results_pkg::*;
(
    input  logic [ACC_W-1:0] a,
    input  logic [IN_W-1:0]  b,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);
    logic [ACC_W:0] wide_s;

    assign wide_s = {a[ACC_W-1], a} + {{(ACC_W+1-IN_W){b[IN_W-1]}}, b};

    // Overflow shows up as disagreement between the two top bits of the widened sum.
    always_comb begin
        sum = wide_s[ACC_W-1:0];
        sat = 1'b0;
        if (wide_s[ACC_W] != wide_s[ACC_W-1]) begin
            sat = 1'b1;
            sum = wide_s[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sum = wide_s[ACC_W-1:0];
        end
    end
endmodule

// File: rtl/results_accumulator.sv
// Write-back stage for the results SRAM: overwrite or saturating read-modify-write of one word.
module results_accumulator
    import results_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_accum,
    input  logic [ADDRESSSIZE-1:0] in_addr,
    input  logic [LANES*IN_W-1:0]  in_data,
    output logic                   sram_we,
    output logic [ADDRESSSIZE-1:0] sram_addr,
    output logic [WORDSIZE-1:0]    sram_wdata,
    input  logic [WORDSIZE-1:0]    sram_rdata,
    output logic                   sat_flag,
    output logic [15:0]            wr_count,
    output logic                   busy
);
    state_t                 state_r;
    state_t                 next_state_s;
    logic                   xfer_s;
    logic [LANES*IN_W-1:0]  in_data_r;
    logic [WORDSIZE-1:0]    wdata_r;
    logic [WORDSIZE-1:0]    ext_s;
    logic [WORDSIZE-1:0]    merged_s;
    logic [LANES-1:0]       lane_sat_s;
    logic                   sram_we_r;
    logic [ADDRESSSIZE-1:0] sram_addr_r;
    logic                   in_ready_r;
    logic                   busy_r;
    logic                   sat_flag_r;
    logic [15:0]            wr_count_r;

    assign xfer_s = in_valid & in_ready_r;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign ext_s[i*ACC_W +: ACC_W] = sext_in(in_data[i*IN_W +: IN_W]);
        sat_add_lane u_lane (
            .a   (sram_rdata[i*ACC_W +: ACC_W]),
            .b   (in_data_r[i*IN_W +: IN_W]),
            .sum (merged_s[i*ACC_W +: ACC_W]),
            .sat (lane_sat_s[i])
        );
    end

    // Next-state logic for the serialized transaction sequencer.
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    next_state_s = in_accum ? READ : WRITE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            READ:    next_state_s = MERGE;
            MERGE:   next_state_s = WRITE;
            WRITE:   next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State and registered outputs; SRAM controls are decoded from the next state
    // so they are valid for the whole READ/WRITE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            in_data_r   <= '0;
            wdata_r     <= '0;
            sram_we_r   <= 1'b0;
            sram_addr_r <= '0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            sat_flag_r  <= 1'b0;
            wr_count_r  <= 16'd0;
        end else begin
            state_r    <= next_state_s;
            sram_we_r  <= (next_state_s == WRITE);
            in_ready_r <= (next_state_s == IDLE);
            busy_r     <= (next_state_s != IDLE);
            if (xfer_s) begin
                sram_addr_r <= in_addr;
                in_data_r   <= in_data;
                if (!in_accum) begin
                    wdata_r <= ext_s;
                end
            end else if (state_r == MERGE) begin
                wdata_r <= merged_s;
                if (|lane_sat_s) begin
                    sat_flag_r <= 1'b1;
                end
            end
            if (state_r == WRITE) begin
                wr_count_r <= wr_count_r + 16'd1;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign busy       = busy_r;
    assign sram_we    = sram_we_r;
    assign sram_addr  = sram_addr_r;
    assign sram_wdata = wdata_r;
    assign sat_flag   = sat_flag_r;
    assign wr_count   = wr_count_r;
endmodule

// File: doc/results_accumulator.md
Name: results_accumulator

Overview:
- Upstream write-back stage for the results SRAM (8 lanes x 20-bit word, 1024 deep).
- Accepts one vector of 8 signed partial sums per handshake from the systolic array's output edge.
- Either overwrites the addressed SRAM word or adds the vector into it (read-modify-write, per-lane saturating).
- Owns the SRAM's write_enable, address and data_in ports, and consumes its registered data_out.

Parameters:
- LANES, 8, number of lanes per word.
- IN_W, 16, signed width of each incoming partial sum.
- ACC_W, 20, signed width of each stored lane; WORDSIZE = LANES*ACC_W = 160.
- ADDRESSSIZE, 10, SRAM address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream vector valid.
- in_ready  out  1  block can accept a vector this cycle.
- in_accum  in  1  1 = add into stored word, 0 = overwrite.
- in_addr  in  ADDRESSSIZE  target word address.
- in_data  in  LANES*IN_W  lane i occupies bits [i*IN_W +: IN_W], signed.
- sram_we  out  1  to SRAM write_enable.
- sram_addr  out  ADDRESSSIZE  to SRAM address.
- sram_wdata  out  LANES*ACC_W  to SRAM data_in.
- sram_rdata  in  LANES*ACC_W  from SRAM data_out. Valid the cycle after a read cycle (one with sram_we=0).
- sat_flag  out  1  sticky; set when any lane saturated since reset.
- wr_count  out  16  number of SRAM writes completed, wraps at 65535->0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset is asynchronous and active-high. All outputs return to 0 except in_ready=1, and state goes to IDLE. A transaction in flight is dropped with no write. sram_we must go to 0 immediately on rst assertion.
- Handshake: transfer when in_valid & in_ready. in_ready = (state == IDLE). Inputs are sampled into registers at transfer; upstream may change them afterwards.
- FSM states:
  - IDLE: on transfer, go to WRITE if in_accum=0, else to READ.
  - READ: one cycle. Drive sram_we=0, sram_addr=latched addr. Go to MERGE.
  - MERGE: one cycle. sram_rdata is valid this cycle. Compute per-lane sat(rdata_i + sext(in_i)) and register the result into the write-data register. Go to WRITE.
  - WRITE: one cycle. Drive sram_we=1, sram_addr=addr, sram_wdata=result. Increment wr_count. Go to IDLE.
- Overwrite path: write data = per-lane sign-extension of in_i to ACC_W. It never saturates.
- Latency from the transfer edge to the SRAM write edge:
  - overwrite: 1 cycle (WRITE).
  - accumulate: 3 cycles (READ, MERGE, WRITE).
- Throughput:
  - overwrite: 1 vector per 2 cycles.
  - accumulate: 1 vector per 4 cycles.
- Outside READ and WRITE, sram_we=0 and sram_addr holds its last value. The SRAM then performs a harmless read, and its data_out is ignored.
- Arithmetic:
  - Sums are computed at ACC_W+1 bits, then clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Any clamp sets sat_flag. sat_flag is cleared only by rst.
- Address hazards: none, because transactions are strictly serialized. Back-to-back accumulates to the same address see the prior write, since the WRITE precedes the next READ.
- in_valid is ignored while busy. No input is lost, because in_ready=0 stalls upstream.
- wr_count counts writes in both modes. It wraps naturally.
- Address wrap: none; addresses are used as given, across the full 0..1023 range.

Decomposition:
- Package results_pkg:
  - constants LANES, IN_W, ACC_W, ADDRESSSIZE.
  - state enum {IDLE, READ, MERGE, WRITE}.
  - ACC_MAX and ACC_MIN localparams.
- Sub-module sat_add_lane:
  - Purely combinational.
  - Inputs: ACC_W-bit a, IN_W-bit b (signed).
  - Outputs: ACC_W-bit saturated sum, 1-bit sat.
  - Instantiated LANES times via generate.

Test Plan:
- Overwrite, addr 5, all lanes 0x7FFF, in_accum=0: sram_we=1 exactly one cycle later with addr 5 and each lane 0x07FFF; in_ready low 1 cycle; wr_count=1.
- Accumulate into addr 5 (SRAM model holds lanes=100), in lanes=-30: read cycle addr 5 with we=0, then write 70 per lane 3 cycles after transfer; sat_flag=0.
- Positive saturation: stored 0x7FFF0 (+524272) + 0x7FFF: written 0x7FFFF (+524287) in all lanes; sat_flag=1 and stays 1 after a later clean overwrite.
- Negative saturation: stored 0x80005 (-524283) + (-16): written 0x80000; sat_flag=1.
- Back-to-back accumulates of +1 to addr 1023 with in_valid held high 8 transfers: final stored lanes = 8; in_ready pattern 1,0,0,0 repeating; wr_count=8.
- Assert rst during MERGE of an accumulate: sram_we never pulses, stored word unchanged, in_ready=1 and busy=0 immediately, wr_count=0.
